// File: rtl/id_issue_ctrl.sv
// ID-stage register scoreboard and issue interlock: issue_o/stall_o are combinational
// off the registered busy mask; the busy mask, inflight count and stall counters update on rising clk.
`ifndef RADDR_WIDTH
`define RADDR_WIDTH 5
`endif

module id_issue_ctrl #(
  parameter int MAX_INFLIGHT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_valid_i,
  input  logic                    reg1_re_i,
  input  logic [`RADDR_WIDTH-1:0] reg1_raddr_i,
  input  logic                    reg2_re_i,
  input  logic [`RADDR_WIDTH-1:0] reg2_raddr_i,
  input  logic                    reg_we_i,
  input  logic [`RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                    wb_we_i,
  input  logic [`RADDR_WIDTH-1:0] wb_waddr_i,
  input  logic                    flush_i,
  output logic                    issue_o,
  output logic                    stall_o,
  output logic [31:0]             busy_mask_o,
  output logic [3:0]              inflight_o,
  output logic [15:0]             stall_cnt_o,
  output logic                    deadlock_o
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [3:0]  MAX_CNT     = 4'(MAX_INFLIGHT);
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
  localparam logic [15:0] CNT_SAT     = 16'hFFFF;

  logic [31:0] busy_q, busy_d;
  logic [3:0]  inflight_q, inflight_d;
  state_e      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        deadlock_q, deadlock_d;

  logic [31:0] wb_mask;
  logic [31:0] pend_eff;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic        wb_release;
  logic        rs1_pend;
  logic        rs2_pend;
  logic        rd_pend;
  logic        cap_full;
  logic        hazard;
  logic        set_en;
  logic        rd_nonzero;

  // A writeback in this cycle hides its register from the hazard check (bypass).
  always_comb begin
    wb_mask = '0;
    if (wb_we_i) begin
      wb_mask = 32'd1 << wb_waddr_i;
    end
    pend_eff   = busy_q & ~wb_mask & ~32'd1;
    wb_release = wb_we_i && (wb_waddr_i != '0) && busy_q[wb_waddr_i];
    rd_nonzero = (reg_waddr_i != '0);
    rs1_pend   = reg1_re_i && pend_eff[reg1_raddr_i];
    rs2_pend   = reg2_re_i && pend_eff[reg2_raddr_i];
    rd_pend    = reg_we_i && pend_eff[reg_waddr_i];
    cap_full   = reg_we_i && rd_nonzero && (inflight_q == MAX_CNT) && !wb_release;
    hazard     = rs1_pend || rs2_pend || rd_pend || cap_full;
  end

  assign issue_o = inst_valid_i && !hazard && !flush_i;
  assign stall_o = inst_valid_i && hazard && !flush_i;

  always_comb begin
    set_en   = issue_o && reg_we_i && rd_nonzero;
    set_mask = '0;
    clr_mask = '0;
    if (set_en) begin
      set_mask = 32'd1 << reg_waddr_i;
    end
    if (wb_release) begin
      clr_mask = 32'd1 << wb_waddr_i;
    end
    // Clear before set so a same-register issue/writeback leaves the new owner pending.
    busy_d = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;

    inflight_d = inflight_q;
    case ({set_en, wb_release})
      2'b10: if (inflight_q < MAX_CNT) inflight_d = inflight_q + 4'd1;
      2'b01: if (inflight_q != 4'd0)   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // Stall run tracker: counts consecutive stalled cycles, saturating.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    deadlock_d  = deadlock_q;
    if (!stall_o) begin
      state_d     = RUN;
      stall_cnt_d = '0;
      deadlock_d  = 1'b0;
    end else begin
      state_d = HOLD;
      if (state_q == RUN) begin
        stall_cnt_d = 16'd1;
      end else if (stall_cnt_q != CNT_SAT) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
      deadlock_d = (stall_cnt_d >= TIMEOUT_CNT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      inflight_q  <= '0;
      state_q     <= RUN;
      stall_cnt_q <= '0;
      deadlock_q  <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      inflight_q  <= inflight_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      deadlock_q  <= deadlock_d;
    end
  end

  assign busy_mask_o = busy_q;
  assign inflight_o  = inflight_q;
  assign stall_cnt_o = stall_cnt_q;
  assign deadlock_o  = deadlock_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(issue_o && stall_o));
      assert (inflight_q <= MAX_CNT);
      assert (!busy_q[0]);
      assert (inflight_q == 4'($countones(busy_q)));
    end
  end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed scenarios plus randomized traffic checked against a per-register pending model.
module tb_id_issue_ctrl;
  localparam int MAXI = 4;
  localparam int TMO  = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i, reg1_re_i, reg2_re_i, reg_we_i, wb_we_i, flush_i;
  logic [4:0]  reg1_raddr_i, reg2_raddr_i, reg_waddr_i, wb_waddr_i;
  logic        issue_o, stall_o, deadlock_o;
  logic [31:0] busy_mask_o;
  logic [3:0]  inflight_o;
  logic [15:0] stall_cnt_o;

  int errors = 0;
  int checks = 0;
  bit pend[32];

  always #5 clk = ~clk;

  id_issue_ctrl #(.MAX_INFLIGHT(MAXI), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i),
    .reg1_re_i(reg1_re_i), .reg1_raddr_i(reg1_raddr_i),
    .reg2_re_i(reg2_re_i), .reg2_raddr_i(reg2_raddr_i),
    .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
    .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .flush_i(flush_i),
    .issue_o(issue_o), .stall_o(stall_o), .busy_mask_o(busy_mask_o),
    .inflight_o(inflight_o), .stall_cnt_o(stall_cnt_o), .deadlock_o(deadlock_o)
  );

  task automatic drive(input logic v, input logic re1, input logic [4:0] a1,
                       input logic re2, input logic [4:0] a2, input logic we,
                       input logic [4:0] wa, input logic wbwe, input logic [4:0] wba,
                       input logic fl);
    inst_valid_i = v;  reg1_re_i = re1; reg1_raddr_i = a1; reg2_re_i = re2;
    reg2_raddr_i = a2; reg_we_i = we;   reg_waddr_i = wa;  wb_we_i = wbwe;
    wb_waddr_i = wba;  flush_i = fl;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit eff(input int r, input logic wbwe, input logic [4:0] wba);
    return (r != 0) && pend[r] && !(wbwe && (int'(wba) == r));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    checks++; if (busy_mask_o !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy_mask_o); end
    checks++; if (inflight_o !== 4'd0) begin errors++; $display("FAIL reset_inflight: got %0d want 0", inflight_o); end
    checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_stallcnt: got %0d want 0", stall_cnt_o); end
    checks++; if (deadlock_o !== 1'b0) begin errors++; $display("FAIL reset_deadlock: got %b want 0", deadlock_o); end
    checks++; if (issue_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL reset_idle_out: got issue=%b stall=%b want 0/0", issue_o, stall_o); end
    drive(1, 1, 5, 1, 6, 1, 7, 0, 0, 0);
    checks++; if (issue_o !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL reset_comb_issue: got issue=%b stall=%b want 1/0", issue_o, stall_o); end
    tick();
    checks++; if (busy_mask_o !== 32'd0) begin errors++; $display("FAIL reset_hold_busy: got %h want 0", busy_mask_o); end
    rst = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_raw();
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    checks++; if (issue_o !== 1'b1) begin errors++; $display("FAIL raw_producer_issue: got %b want 1", issue_o); end
    tick();
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (stall_o !== 1'b1 || issue_o !== 1'b0) begin errors++; $display("FAIL raw_stall: got stall=%b issue=%b want 1/0", stall_o, issue_o); end
    checks++; if (busy_mask_o !== 32'h20) begin errors++; $display("FAIL raw_busy: got %h want 00000020", busy_mask_o); end
    tick();
    checks++; if (stall_cnt_o !== 16'd1) begin errors++; $display("FAIL raw_stallcnt: got %0d want 1", stall_cnt_o); end
    drive(1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
    checks++; if (issue_o !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL raw_bypass_issue: got issue=%b stall=%b want 1/0", issue_o, stall_o); end
    tick();
    idle();
    checks++; if (busy_mask_o !== 32'd0 || inflight_o !== 4'd0) begin errors++; $display("FAIL raw_release: got busy=%h infl=%0d want 0/0", busy_mask_o, inflight_o); end
    checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL raw_stallcnt_clear: got %0d want 0", stall_cnt_o); end
  endtask

  task automatic test_capacity();
    for (int r = 1; r <= 4; r++) begin
      drive(1, 0, 0, 0, 0, 1, 5'(r), 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
    checks++; if (inflight_o !== 4'd4 || busy_mask_o !== 32'h1E) begin errors++; $display("FAIL cap_full_state: got infl=%0d busy=%h want 4/0000001e", inflight_o, busy_mask_o); end
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL cap_stall: got %b want 1", stall_o); end
    drive(1, 0, 0, 0, 0, 1, 6, 1, 1, 0);
    checks++; if (issue_o !== 1'b1) begin errors++; $display("FAIL cap_release_issue: got %b want 1", issue_o); end
    tick();
    checks++; if (inflight_o !== 4'd4 || busy_mask_o !== 32'h5C) begin errors++; $display("FAIL cap_swap: got infl=%0d busy=%h want 4/0000005c", inflight_o, busy_mask_o); end
    for (int r = 2; r <= 6; r++) begin
      if (r != 5) begin
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5'(r), 0);
        tick();
      end
    end
    idle();
    checks++; if (inflight_o !== 4'd0 || busy_mask_o !== 32'd0) begin errors++; $display("FAIL cap_drain: got infl=%0d busy=%h want 0/0", inflight_o, busy_mask_o); end
  endtask

  task automatic test_x0();
    drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    tick();
    drive(1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    checks++; if (issue_o !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL x0_issue: got issue=%b stall=%b want 1/0", issue_o, stall_o); end
    tick();
    checks++; if (busy_mask_o !== 32'h200 || inflight_o !== 4'd1) begin errors++; $display("FAIL x0_nochange: got busy=%h infl=%0d want 00000200/1", busy_mask_o, inflight_o); end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
    tick();
    checks++; if (busy_mask_o !== 32'h200 || inflight_o !== 4'd1) begin errors++; $display("FAIL wb_nonpending: got busy=%h infl=%0d want 00000200/1", busy_mask_o, inflight_o); end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    tick();
    idle();
    checks++; if (busy_mask_o !== 32'd0 || inflight_o !== 4'd0) begin errors++; $display("FAIL x0_cleanup: got busy=%h infl=%0d want 0/0", busy_mask_o, inflight_o); end
  endtask

  task automatic test_flush();
    drive(1, 0, 0, 0, 0, 1, 11, 0, 0, 1);
    checks++; if (issue_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL flush_clean: got issue=%b stall=%b want 0/0", issue_o, stall_o); end
    tick();
    checks++; if (busy_mask_o !== 32'd0 || inflight_o !== 4'd0) begin errors++; $display("FAIL flush_noscore: got busy=%h infl=%0d want 0/0", busy_mask_o, inflight_o); end
    drive(1, 0, 0, 0, 0, 1, 11, 0, 0, 0);
    tick();
    drive(1, 1, 11, 0, 0, 0, 0, 0, 0, 1);
    checks++; if (issue_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL flush_hazard: got issue=%b stall=%b want 0/0", issue_o, stall_o); end
    tick();
    checks++; if (stall_cnt_o !== 16'd0 || busy_mask_o !== 32'h800) begin errors++; $display("FAIL flush_keep: got cnt=%0d busy=%h want 0/00000800", stall_cnt_o, busy_mask_o); end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 11, 0);
    tick();
    idle();
  endtask

  task automatic test_timeout();
    drive(1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    tick();
    drive(1, 0, 0, 1, 8, 0, 0, 0, 0, 0);
    for (int k = 1; k <= TMO; k++) begin
      tick();
      if (k == TMO - 1) begin
        checks++; if (stall_cnt_o !== 16'(TMO - 1) || deadlock_o !== 1'b0) begin errors++; $display("FAIL timeout_pre: got cnt=%0d dl=%b want %0d/0", stall_cnt_o, deadlock_o, TMO - 1); end
      end
    end
    checks++; if (stall_cnt_o !== 16'(TMO) || deadlock_o !== 1'b1) begin errors++; $display("FAIL timeout_hit: got cnt=%0d dl=%b want %0d/1", stall_cnt_o, deadlock_o, TMO); end
    drive(1, 0, 0, 1, 8, 0, 0, 1, 8, 0);
    checks++; if (issue_o !== 1'b1) begin errors++; $display("FAIL timeout_release_issue: got %b want 1", issue_o); end
    tick();
    idle();
    checks++; if (stall_cnt_o !== 16'd0 || deadlock_o !== 1'b0 || busy_mask_o !== 32'd0) begin errors++; $display("FAIL timeout_clear: got cnt=%0d dl=%b busy=%h want 0/0/0", stall_cnt_o, deadlock_o, busy_mask_o); end
  endtask

  task automatic test_async_reset();
    for (int r = 1; r <= 4; r++) begin
      drive(1, 0, 0, 0, 0, 1, 5'(r), 0, 0, 0);
      tick();
    end
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checks++; if (busy_mask_o !== 32'h1E || inflight_o !== 4'd4 || stall_cnt_o !== 16'd2) begin errors++; $display("FAIL areset_pre: got busy=%h infl=%0d cnt=%0d want 0000001e/4/2", busy_mask_o, inflight_o, stall_cnt_o); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy_mask_o !== 32'd0 || inflight_o !== 4'd0) begin errors++; $display("FAIL areset_score: got busy=%h infl=%0d want 0/0", busy_mask_o, inflight_o); end
    checks++; if (stall_cnt_o !== 16'd0 || deadlock_o !== 1'b0) begin errors++; $display("FAIL areset_fsm: got cnt=%0d dl=%b want 0/0", stall_cnt_o, deadlock_o); end
    checks++; if (issue_o !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL areset_comb: got issue=%b stall=%b want 1/0", issue_o, stall_o); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (issue_o !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL areset_first_issue: got issue=%b stall=%b want 1/0", issue_o, stall_o); end
    tick();
    idle();
  endtask

  task automatic test_random();
    int   run;
    int   cnt;
    logic v, re1, re2, we, wbwe, fl, rel, hz, e_issue, e_stall;
    logic [4:0] a1, a2, wa, wba;
    logic [31:0] e_busy;
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    run = 0;
    for (int n = 0; n < 3000; n++) begin
      v    = ($urandom_range(0, 99) < 80);
      re1  = 1'($urandom_range(0, 1));
      re2  = 1'($urandom_range(0, 1));
      we   = ($urandom_range(0, 99) < 60);
      wbwe = ($urandom_range(0, 99) < 40);
      fl   = ($urandom_range(0, 99) < 8);
      a1   = 5'($urandom_range(0, 7));
      a2   = 5'($urandom_range(0, 7));
      wa   = 5'($urandom_range(0, 7));
      wba  = 5'($urandom_range(0, 7));
      drive(v, re1, a1, re2, a2, we, wa, wbwe, wba, fl);
      cnt    = 0;
      e_busy = '0;
      for (int i = 0; i < 32; i++) begin
        if (pend[i]) begin
          cnt++;
          e_busy[i] = 1'b1;
        end
      end
      rel     = wbwe && (wba != 0) && pend[wba];
      hz      = (re1 && eff(int'(a1), wbwe, wba)) || (re2 && eff(int'(a2), wbwe, wba)) ||
                (we && eff(int'(wa), wbwe, wba)) || (we && wa != 0 && cnt == MAXI && !rel);
      e_issue = v && !hz && !fl;
      e_stall = v && hz && !fl;
      checks++; if (issue_o !== e_issue || stall_o !== e_stall) begin errors++; $display("FAIL rnd_ctrl[%0d]: got issue=%b stall=%b want %b/%b", n, issue_o, stall_o, e_issue, e_stall); end
      checks++; if (busy_mask_o !== e_busy || inflight_o !== 4'(cnt)) begin errors++; $display("FAIL rnd_score[%0d]: got busy=%h infl=%0d want %h/%0d", n, busy_mask_o, inflight_o, e_busy, cnt); end
      checks++; if (stall_cnt_o !== 16'((run > 65535) ? 65535 : run) || deadlock_o !== (run >= TMO)) begin errors++; $display("FAIL rnd_stall[%0d]: got cnt=%0d dl=%b want %0d/%b", n, stall_cnt_o, deadlock_o, run, run >= TMO); end
      tick();
      if (rel) pend[wba] = 1'b0;
      if (e_issue && we && wa != 0) pend[wa] = 1'b1;
      run = e_stall ? run + 1 : 0;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_capacity();
    test_x0();
    test_flush();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
